german_system_param: RTL and testbench
======================================

# german_system_param

Parametrised successor to the fixed three-client German cache-coherence `system` generated from the Murphi model. Generalises client count and data width, adds an explicit rule/client/data selector, a registered fire acknowledge, a saturating fire counter and observation ports. It is the DUT for equivalence and property checks: a formal engine or bench picks one rule instance per cycle, and the block executes it atomically when its guard holds.

## Interface
- NUM_CLIENTS, 3, number of caches (2..16); CW = clog2(NUM_CLIENTS)
- DATA_WIDTH, 2, width of every data field
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- io_rule  in  4  rule id: 0 idle, 1 Store, 2 SendReqS, 3 SendReqE, 4 RecvReqS, 5 RecvReqE, 6 SendInv, 7 SendInvAck, 8 RecvInvAck, 9 SendGntS, 10 SendGntE, 11 RecvGntS, 12 RecvGntE; 13..15 illegal
- io_client  in  CW  client index i for the rule
- io_data  in  DATA_WIDTH  store value (Store only)
- io_guard  out  1  combinational: selected rule's guard true this cycle
- io_fired  out  1  registered: a rule executed on the previous edge
- io_fire_count  out  16  saturating count of executed rules
- io_cur_cmd  out  3  CurCmd register
- io_ex_gntd  out  1  ExGntd register
- io_inv_ok  out  1  coherence invariants hold on current state

## Operation
- State: Cache[i].{State,Data}, Chan1/2/3[i].{Cmd,Data}, InvSet[i], ShrSet[i], ExGntd, CurCmd, CurPtr, MemData, AuxData.
- Encodings: CacheState I=0,S=1,E=2. MsgCmd Empty=0, ReqS=1, ReqE=2, Inv=3, InvAck=4, GntS=5, GntE=6.
- Reset: all Cmd=Empty, all State=I, all Data/MemData/AuxData=0, InvSet=ShrSet=0, ExGntd=0, CurPtr=0, io_fired=0, io_fire_count=0.
- Guards/actions (i = io_client):
  - Store: State[i]=E -> Data[i]:=io_data, AuxData:=io_data.
  - SendReqS: Chan1[i]=Empty & State[i]=I -> Chan1[i]:=ReqS. SendReqE: same with State in {I,S} -> ReqE.
  - RecvReqS/E: CurCmd=Empty & Chan1[i]=ReqS/ReqE -> CurCmd:=that cmd, CurPtr:=i, Chan1[i]:=Empty, InvSet:=ShrSet (all j).
  - SendInv: Chan2[i]=Empty & InvSet[i] & (CurCmd=ReqE | CurCmd=ReqS & ExGntd) -> Chan2[i]:=Inv, InvSet[i]:=0.
  - SendInvAck: Chan2[i]=Inv & Chan3[i]=Empty -> Chan2[i]:=Empty, Chan3[i]:=InvAck, Chan3[i].Data:=Data[i] if State[i]=E, State[i]:=I.
  - RecvInvAck: Chan3[i]=InvAck & CurCmd!=Empty -> Chan3[i]:=Empty, ShrSet[i]:=0; if ExGntd: ExGntd:=0, MemData:=Chan3[i].Data.
  - SendGntS: CurCmd=ReqS & CurPtr=i & Chan2[i]=Empty & !ExGntd -> Chan2[i]:=GntS, Chan2[i].Data:=MemData, ShrSet[i]:=1, CurCmd:=Empty.
  - SendGntE: as GntS plus CurCmd=ReqE and all ShrSet=0; also ExGntd:=1.
  - RecvGntS/E: Chan2[i]=GntS/GntE -> State[i]:=S/E, Data[i]:=Chan2[i].Data, Chan2[i]:=Empty.
- Rule 0, ids 13..15, or io_client >= NUM_CLIENTS: io_guard=0, no state change.
- Unlisted fields retain value; exactly one rule instance per cycle.

## Timing
- io_guard combinational from state and inputs, same cycle.
- All state updates on the edge where io_guard=1; io_fired=1 for exactly the following cycle.
- io_fire_count increments on each executing edge; holds at 16'hFFFF.
- Observation outputs reflect registers; io_inv_ok combinational from registers.
- reset=1 overrides any rule that edge; io_fired=0 next cycle, count cleared.

## Configuration
- GERMAN_INVARIANT_EN defined: io_inv_ok = CtrlProp & DataProp (CtrlProp: for i!=j, State[i]=E -> State[j]=I; State[i]=S -> State[j] in {I,S}. DataProp: !ExGntd -> MemData=AuxData; State[i]!=I -> Data[i]=AuxData); simulation assertions fire when io_inv_ok=0 outside reset.
- Undefined: io_inv_ok tied to 1, no checker logic.

## Structure
- Package german_pkg: CacheState, MsgCmd, RuleId enums, cache/channel structs, CW helper.
- Sub-module german_inv_checker (state in, ok out), instantiated only under GERMAN_INVARIANT_EN.

## Test plan
- N=3,W=2: reset -> all Cmd=0, io_fire_count=0, io_inv_ok=1.
- Client 1: SendReqE, RecvReqE, SendGntE, RecvGntE -> State[1]=E, ExGntd=1, io_fire_count=4; then Store 2'b10 -> AuxData=Data[1]=2.
- Then client 0 ReqS/RecvReqS, SendInv(1), SendInvAck(1), RecvInvAck(1), SendGntS(0), RecvGntS(0) -> MemData=2, Data[0]=2, State[1]=I.
- Guard false (SendGntE with ShrSet[2]=1) -> io_guard=0, state unchanged, io_fired=0.
- io_client=3 with N=3, or rule 14 -> no change; reset asserted with valid rule -> rule ignored.
- 65540 forced fires -> io_fire_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/german_pkg.sv
// Shared encodings for the parametrised German coherence model: cache states,
// message commands, rule ids and the client-index width helper.
package german_pkg;

  typedef enum logic [1:0] {
    CS_I = 2'd0,
    CS_S = 2'd1,
    CS_E = 2'd2
  } cache_state_e;

  typedef enum logic [2:0] {
    MC_EMPTY   = 3'd0,
    MC_REQ_S   = 3'd1,
    MC_REQ_E   = 3'd2,
    MC_INV     = 3'd3,
    MC_INV_ACK = 3'd4,
    MC_GNT_S   = 3'd5,
    MC_GNT_E   = 3'd6
  } msg_cmd_e;

  typedef enum logic [3:0] {
    R_IDLE         = 4'd0,
    R_STORE        = 4'd1,
    R_SEND_REQ_S   = 4'd2,
    R_SEND_REQ_E   = 4'd3,
    R_RECV_REQ_S   = 4'd4,
    R_RECV_REQ_E   = 4'd5,
    R_SEND_INV     = 4'd6,
    R_SEND_INV_ACK = 4'd7,
    R_RECV_INV_ACK = 4'd8,
    R_SEND_GNT_S   = 4'd9,
    R_SEND_GNT_E   = 4'd10,
    R_RECV_GNT_S   = 4'd11,
    R_RECV_GNT_E   = 4'd12
  } rule_e;

  localparam int FIRE_CNT_W = 16;

  // Client index width; a single-bit index is kept even for two clients.
  function automatic int client_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/german_inv_checker.sv
// Combinational coherence invariant checker (CtrlProp & DataProp) over flattened
// cache state; zero latency, no flow control. Compiled only with GERMAN_INVARIANT_EN.
`ifdef GERMAN_INVARIANT_EN
module german_inv_checker
  import german_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int DATA_WIDTH  = 2
) (
  input  logic [2*NUM_CLIENTS-1:0]          cache_state,
  input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] cache_data,
  input  logic                              ex_gntd,
  input  logic [DATA_WIDTH-1:0]             mem_data,
  input  logic [DATA_WIDTH-1:0]             aux_data,
  output logic                              ok
);

  logic ctrl_ok;
  logic data_ok;

  always_comb begin
    ctrl_ok = 1'b1;
    data_ok = ex_gntd || (mem_data == aux_data);
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cache_state[2*i +: 2] != CS_I && cache_data[DATA_WIDTH*i +: DATA_WIDTH] != aux_data)
        data_ok = 1'b0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
        if (i != j) begin
          if (cache_state[2*i +: 2] == CS_E && cache_state[2*j +: 2] != CS_I)
            ctrl_ok = 1'b0;
          if (cache_state[2*i +: 2] == CS_S && cache_state[2*j +: 2] != CS_I &&
              cache_state[2*j +: 2] != CS_S)
            ctrl_ok = 1'b0;
        end
      end
    end
  end

  assign ok = ctrl_ok & data_ok;

endmodule
`endif

// File: rtl/german_system_param.sv
// German protocol system: executes the selected rule atomically on the edge where its
// guard holds (guard same cycle, io_fired next cycle); no backpressure. GERMAN_INVARIANT_EN adds the checker.
module german_system_param
  import german_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int DATA_WIDTH  = 2,
  localparam int CW         = client_w(NUM_CLIENTS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            io_rule,
  input  logic [CW-1:0]         io_client,
  input  logic [DATA_WIDTH-1:0] io_data,
  output logic                  io_guard,
  output logic                  io_fired,
  output logic [15:0]           io_fire_count,
  output logic [2:0]            io_cur_cmd,
  output logic                  io_ex_gntd,
  output logic                  io_inv_ok
);

  typedef struct packed {
    cache_state_e          state;
    logic [DATA_WIDTH-1:0] data;
  } cache_t;

  typedef struct packed {
    msg_cmd_e              cmd;
    logic [DATA_WIDTH-1:0] data;
  } msg_t;

  cache_t                  cache_q [NUM_CLIENTS];
  cache_t                  cache_n [NUM_CLIENTS];
  msg_t                    ch1_q   [NUM_CLIENTS];
  msg_t                    ch1_n   [NUM_CLIENTS];
  msg_t                    ch2_q   [NUM_CLIENTS];
  msg_t                    ch2_n   [NUM_CLIENTS];
  msg_t                    ch3_q   [NUM_CLIENTS];
  msg_t                    ch3_n   [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]  inv_set_q, inv_set_n;
  logic [NUM_CLIENTS-1:0]  shr_set_q, shr_set_n;
  logic                    ex_gntd_q, ex_gntd_n;
  msg_cmd_e                cur_cmd_q, cur_cmd_n;
  logic [CW-1:0]           cur_ptr_q, cur_ptr_n;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_n;
  logic [DATA_WIDTH-1:0]   aux_data_q, aux_data_n;
  logic                    fired_q;
  logic [FIRE_CNT_W-1:0]   fire_count_q;

  logic                    client_ok;
  logic [CW-1:0]           ci;
  logic                    guard;

  // Out-of-range clients are folded onto index 0 only to keep array reads legal;
  // client_ok blocks every rule for them.
  assign client_ok = ({1'b0, io_client} < (CW+1)'(NUM_CLIENTS));
  assign ci        = client_ok ? io_client : '0;

  always_comb begin
    cache_n    = cache_q;
    ch1_n      = ch1_q;
    ch2_n      = ch2_q;
    ch3_n      = ch3_q;
    inv_set_n  = inv_set_q;
    shr_set_n  = shr_set_q;
    ex_gntd_n  = ex_gntd_q;
    cur_cmd_n  = cur_cmd_q;
    cur_ptr_n  = cur_ptr_q;
    mem_data_n = mem_data_q;
    aux_data_n = aux_data_q;
    guard      = 1'b0;
    if (client_ok) begin
      case (io_rule)
        R_STORE: if (cache_q[ci].state == CS_E) begin
          guard             = 1'b1;
          cache_n[ci].data  = io_data;
          aux_data_n        = io_data;
        end
        R_SEND_REQ_S: if (ch1_q[ci].cmd == MC_EMPTY && cache_q[ci].state == CS_I) begin
          guard           = 1'b1;
          ch1_n[ci].cmd   = MC_REQ_S;
        end
        R_SEND_REQ_E: if (ch1_q[ci].cmd == MC_EMPTY &&
                          (cache_q[ci].state == CS_I || cache_q[ci].state == CS_S)) begin
          guard           = 1'b1;
          ch1_n[ci].cmd   = MC_REQ_E;
        end
        R_RECV_REQ_S, R_RECV_REQ_E: begin
          if (cur_cmd_q == MC_EMPTY &&
              ch1_q[ci].cmd == ((io_rule == R_RECV_REQ_S) ? MC_REQ_S : MC_REQ_E)) begin
            guard         = 1'b1;
            cur_cmd_n     = ch1_q[ci].cmd;
            cur_ptr_n     = ci;
            ch1_n[ci].cmd = MC_EMPTY;
            inv_set_n     = shr_set_q;
          end
        end
        R_SEND_INV: if (ch2_q[ci].cmd == MC_EMPTY && inv_set_q[ci] &&
                        (cur_cmd_q == MC_REQ_E || (cur_cmd_q == MC_REQ_S && ex_gntd_q))) begin
          guard         = 1'b1;
          ch2_n[ci].cmd = MC_INV;
          inv_set_n[ci] = 1'b0;
        end
        R_SEND_INV_ACK: if (ch2_q[ci].cmd == MC_INV && ch3_q[ci].cmd == MC_EMPTY) begin
          guard             = 1'b1;
          ch2_n[ci].cmd     = MC_EMPTY;
          ch3_n[ci].cmd     = MC_INV_ACK;
          if (cache_q[ci].state == CS_E)
            ch3_n[ci].data  = cache_q[ci].data;
          cache_n[ci].state = CS_I;
        end
        R_RECV_INV_ACK: if (ch3_q[ci].cmd == MC_INV_ACK && cur_cmd_q != MC_EMPTY) begin
          guard         = 1'b1;
          ch3_n[ci].cmd = MC_EMPTY;
          shr_set_n[ci] = 1'b0;
          if (ex_gntd_q) begin
            ex_gntd_n  = 1'b0;
            mem_data_n = ch3_q[ci].data;
          end
        end
        R_SEND_GNT_S, R_SEND_GNT_E: begin
          if (cur_ptr_q == ci && ch2_q[ci].cmd == MC_EMPTY && !ex_gntd_q &&
              ((io_rule == R_SEND_GNT_S && cur_cmd_q == MC_REQ_S) ||
               (io_rule == R_SEND_GNT_E && cur_cmd_q == MC_REQ_E && shr_set_q == '0))) begin
            guard          = 1'b1;
            ch2_n[ci].cmd  = (io_rule == R_SEND_GNT_S) ? MC_GNT_S : MC_GNT_E;
            ch2_n[ci].data = mem_data_q;
            shr_set_n[ci]  = 1'b1;
            cur_cmd_n      = MC_EMPTY;
            if (io_rule == R_SEND_GNT_E)
              ex_gntd_n    = 1'b1;
          end
        end
        R_RECV_GNT_S, R_RECV_GNT_E: begin
          if (ch2_q[ci].cmd == ((io_rule == R_RECV_GNT_S) ? MC_GNT_S : MC_GNT_E)) begin
            guard             = 1'b1;
            cache_n[ci].state = (io_rule == R_RECV_GNT_S) ? CS_S : CS_E;
            cache_n[ci].data  = ch2_q[ci].data;
            ch2_n[ci].cmd     = MC_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

  // The next-state copies equal the current state whenever the guard is false.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        cache_q[i].state <= CS_I;
        cache_q[i].data  <= '0;
        ch1_q[i].cmd     <= MC_EMPTY;
        ch1_q[i].data    <= '0;
        ch2_q[i].cmd     <= MC_EMPTY;
        ch2_q[i].data    <= '0;
        ch3_q[i].cmd     <= MC_EMPTY;
        ch3_q[i].data    <= '0;
      end
      inv_set_q    <= '0;
      shr_set_q    <= '0;
      ex_gntd_q    <= 1'b0;
      cur_cmd_q    <= MC_EMPTY;
      cur_ptr_q    <= '0;
      mem_data_q   <= '0;
      aux_data_q   <= '0;
      fired_q      <= 1'b0;
      fire_count_q <= '0;
    end else begin
      cache_q    <= cache_n;
      ch1_q      <= ch1_n;
      ch2_q      <= ch2_n;
      ch3_q      <= ch3_n;
      inv_set_q  <= inv_set_n;
      shr_set_q  <= shr_set_n;
      ex_gntd_q  <= ex_gntd_n;
      cur_cmd_q  <= cur_cmd_n;
      cur_ptr_q  <= cur_ptr_n;
      mem_data_q <= mem_data_n;
      aux_data_q <= aux_data_n;
      fired_q    <= guard;
      if (guard && fire_count_q != '1)
        fire_count_q <= fire_count_q + 1'b1;
    end
  end

  assign io_guard      = guard;
  assign io_fired      = fired_q;
  assign io_fire_count = fire_count_q;
  assign io_cur_cmd    = cur_cmd_q;
  assign io_ex_gntd    = ex_gntd_q;

`ifdef GERMAN_INVARIANT_EN
  logic [2*NUM_CLIENTS-1:0]          state_flat;
  logic [DATA_WIDTH*NUM_CLIENTS-1:0] data_flat;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      state_flat[2*i +: 2]                   = cache_q[i].state;
      data_flat[DATA_WIDTH*i +: DATA_WIDTH]  = cache_q[i].data;
    end
  end

  german_inv_checker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_inv_checker (
    .cache_state (state_flat),
    .cache_data  (data_flat),
    .ex_gntd     (ex_gntd_q),
    .mem_data    (mem_data_q),
    .aux_data    (aux_data_q),
    .ok          (io_inv_ok)
  );

  inv_holds: assert property (@(posedge clock) disable iff (reset) io_inv_ok)
    else $error("coherence invariant violated");
`else
  assign io_inv_ok = 1'b1;
`endif

endmodule

// File: tb/tb_german_system_param.sv
// Scenario bench for german_system_param (3 clients, 2-bit data): scoreboard of
// per-edge expectations plus per-scenario guard and internal state checks.
module tb_german_system_param;
  import german_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  io_rule = 4'd0;
  logic [1:0]  io_client = 2'd0;
  logic [1:0]  io_data = 2'd0;
  logic        io_guard;
  logic        io_fired;
  logic [15:0] io_fire_count;
  logic [2:0]  io_cur_cmd;
  logic        io_ex_gntd;
  logic        io_inv_ok;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic        fired;
    logic [2:0]  cmd;
    logic        ex;
    logic [15:0] count;
  } sb_t;

  typedef struct {
    logic [3:0] rule;
    logic [1:0] client;
    logic [1:0] data;
    logic       guard;
    logic [2:0] cmd;
    logic       ex;
  } step_t;

  sb_t         sb[$];
  logic [15:0] exp_count = 16'd0;

  german_system_param #(.NUM_CLIENTS(3), .DATA_WIDTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_rule       (io_rule),
    .io_client     (io_client),
    .io_data       (io_data),
    .io_guard      (io_guard),
    .io_fired      (io_fired),
    .io_fire_count (io_fire_count),
    .io_cur_cmd    (io_cur_cmd),
    .io_ex_gntd    (io_ex_gntd),
    .io_inv_ok     (io_inv_ok)
  );

  always #5 clock = ~clock;

  // One cycle of stimulus; records what the following edge must produce.
  task automatic drive(input logic [3:0] rule, input logic [1:0] client, input logic [1:0] data,
                       input logic rst, input logic fire, input logic [2:0] cmd, input logic ex);
    sb_t e;
    @(negedge clock);
    reset = rst; io_rule = rule; io_client = client; io_data = data;
    if (rst) exp_count = 16'd0;
    else if (fire && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    e.fired = fire & ~rst; e.cmd = cmd; e.ex = ex; e.count = exp_count;
    sb.push_back(e);
  endtask

  always @(posedge clock) begin
    sb_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (io_fired !== e.fired || io_cur_cmd !== e.cmd || io_ex_gntd !== e.ex ||
          io_fire_count !== e.count) begin
        failures++;
        $display("FAIL scoreboard @%0t: fired=%0b cmd=%0d ex=%0b count=%0d, required fired=%0b cmd=%0d ex=%0b count=%0d",
                 $time, io_fired, io_cur_cmd, io_ex_gntd, io_fire_count, e.fired, e.cmd, e.ex, e.count);
      end
    end
  end

  task automatic test_reset();
    drive(R_IDLE, 2'd0, 2'd0, 1'b1, 1'b0, MC_EMPTY, 1'b0);
    @(posedge clock); #1;
    tests++;
    if (io_fire_count !== 16'd0 || io_fired !== 1'b0 || io_inv_ok !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: count=%0d fired=%0b inv_ok=%0b, required 0 0 1", io_fire_count, io_fired, io_inv_ok);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dut.ch1_q[i].cmd !== MC_EMPTY || dut.ch2_q[i].cmd !== MC_EMPTY ||
          dut.ch3_q[i].cmd !== MC_EMPTY || dut.cache_q[i].state !== CS_I) begin
        failures++;
        $display("FAIL reset_client%0d: ch1=%0d ch2=%0d ch3=%0d state=%0d, required all 0", i,
                 dut.ch1_q[i].cmd, dut.ch2_q[i].cmd, dut.ch3_q[i].cmd, dut.cache_q[i].state);
      end
    end
    drive(R_IDLE, 2'd0, 2'd0, 1'b0, 1'b0, MC_EMPTY, 1'b0);
  endtask

  task automatic test_exclusive();
    step_t s[4];
    s = '{'{R_SEND_REQ_E, 2'd1, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_REQ_E, 2'd1, 2'd0, 1'b1, MC_REQ_E, 1'b0},
          '{R_SEND_GNT_E, 2'd1, 2'd0, 1'b1, MC_EMPTY, 1'b1},
          '{R_RECV_GNT_E, 2'd1, 2'd0, 1'b1, MC_EMPTY, 1'b1}};
    foreach (s[k]) begin
      drive(s[k].rule, s[k].client, s[k].data, 1'b0, s[k].guard, s[k].cmd, s[k].ex);
      #1; tests++;
      if (io_guard !== s[k].guard) begin
        failures++;
        $display("FAIL excl_guard step %0d: io_guard=%0b required %0b", k, io_guard, s[k].guard);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (dut.cache_q[1].state !== CS_E || io_ex_gntd !== 1'b1 || io_fire_count !== 16'd4) begin
      failures++;
      $display("FAIL excl_state: state1=%0d ex=%0b count=%0d, required 2 1 4", dut.cache_q[1].state, io_ex_gntd, io_fire_count);
    end
  endtask

  task automatic test_store();
    drive(R_STORE, 2'd1, 2'b10, 1'b0, 1'b1, MC_EMPTY, 1'b1);
    #1; tests++;
    if (io_guard !== 1'b1) begin
      failures++;
      $display("FAIL store_guard: io_guard=%0b required 1", io_guard);
    end
    @(posedge clock); #1;
    tests++;
    if (dut.aux_data_q !== 2'd2 || dut.cache_q[1].data !== 2'd2) begin
      failures++;
      $display("FAIL store_data: aux=%0d data1=%0d, required 2 2", dut.aux_data_q, dut.cache_q[1].data);
    end
  endtask

  task automatic test_shared_inv();
    step_t s[7];
    s = '{'{R_SEND_REQ_S,   2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b1},
          '{R_RECV_REQ_S,   2'd0, 2'd0, 1'b1, MC_REQ_S, 1'b1},
          '{R_SEND_INV,     2'd1, 2'd0, 1'b1, MC_REQ_S, 1'b1},
          '{R_SEND_INV_ACK, 2'd1, 2'd0, 1'b1, MC_REQ_S, 1'b1},
          '{R_RECV_INV_ACK, 2'd1, 2'd0, 1'b1, MC_REQ_S, 1'b0},
          '{R_SEND_GNT_S,   2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_GNT_S,   2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b0}};
    foreach (s[k]) begin
      drive(s[k].rule, s[k].client, s[k].data, 1'b0, s[k].guard, s[k].cmd, s[k].ex);
      #1; tests++;
      if (io_guard !== s[k].guard) begin
        failures++;
        $display("FAIL shared_guard step %0d: io_guard=%0b required %0b", k, io_guard, s[k].guard);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (dut.mem_data_q !== 2'd2 || dut.cache_q[0].data !== 2'd2 || dut.cache_q[1].state !== CS_I ||
        dut.cache_q[0].state !== CS_S || io_inv_ok !== 1'b1) begin
      failures++;
      $display("FAIL shared_state: mem=%0d data0=%0d state1=%0d state0=%0d inv_ok=%0b, required 2 2 0 1 1",
               dut.mem_data_q, dut.cache_q[0].data, dut.cache_q[1].state, dut.cache_q[0].state, io_inv_ok);
    end
  endtask

  task automatic test_guard_false();
    step_t s[8];
    s = '{'{R_SEND_REQ_S, 2'd2, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_REQ_S, 2'd2, 2'd0, 1'b1, MC_REQ_S, 1'b0},
          '{R_SEND_GNT_S, 2'd2, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_GNT_S, 2'd2, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_SEND_REQ_E, 2'd1, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_REQ_E, 2'd1, 2'd0, 1'b1, MC_REQ_E, 1'b0},
          '{R_SEND_GNT_S, 2'd1, 2'd0, 1'b0, MC_REQ_E, 1'b0},
          '{R_SEND_GNT_E, 2'd1, 2'd0, 1'b0, MC_REQ_E, 1'b0}};
    foreach (s[k]) begin
      drive(s[k].rule, s[k].client, s[k].data, 1'b0, s[k].guard, s[k].cmd, s[k].ex);
      #1; tests++;
      if (io_guard !== s[k].guard) begin
        failures++;
        $display("FAIL gfalse_guard step %0d: io_guard=%0b required %0b", k, io_guard, s[k].guard);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (dut.shr_set_q !== 3'b101 || dut.ch2_q[1].cmd !== MC_EMPTY || io_fired !== 1'b0 ||
        io_ex_gntd !== 1'b0) begin
      failures++;
      $display("FAIL gfalse_state: shr=%b ch2_1=%0d fired=%0b ex=%0b, required 101 0 0 0",
               dut.shr_set_q, dut.ch2_q[1].cmd, io_fired, io_ex_gntd);
    end
  endtask

  task automatic test_illegal();
    step_t s[3];
    s = '{'{R_SEND_INV, 2'd3, 2'd0, 1'b0, MC_REQ_E, 1'b0},
          '{4'd14,      2'd0, 2'd0, 1'b0, MC_REQ_E, 1'b0},
          '{R_SEND_INV, 2'd0, 2'd0, 1'b1, MC_REQ_E, 1'b0}};
    foreach (s[k]) begin
      drive(s[k].rule, s[k].client, s[k].data, 1'b0, s[k].guard, s[k].cmd, s[k].ex);
      #1; tests++;
      if (io_guard !== s[k].guard) begin
        failures++;
        $display("FAIL illegal_guard step %0d: io_guard=%0b required %0b", k, io_guard, s[k].guard);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (dut.ch2_q[0].cmd !== MC_INV || dut.inv_set_q !== 3'b100) begin
      failures++;
      $display("FAIL illegal_state: ch2_0=%0d inv_set=%b, required 3 100", dut.ch2_q[0].cmd, dut.inv_set_q);
    end
  endtask

  task automatic test_reset_override();
    drive(R_SEND_INV, 2'd2, 2'd0, 1'b1, 1'b0, MC_EMPTY, 1'b0);
    @(posedge clock); #1;
    tests++;
    if (dut.ch2_q[2].cmd !== MC_EMPTY || dut.inv_set_q !== 3'b000 || io_fired !== 1'b0 ||
        io_fire_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_override: ch2_2=%0d inv_set=%b fired=%0b count=%0d, required 0 000 0 0",
               dut.ch2_q[2].cmd, dut.inv_set_q, io_fired, io_fire_count);
    end
    drive(R_IDLE, 2'd0, 2'd0, 1'b0, 1'b0, MC_EMPTY, 1'b0);
  endtask

  task automatic test_saturation();
    step_t s[4];
    s = '{'{R_SEND_REQ_E, 2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b0},
          '{R_RECV_REQ_E, 2'd0, 2'd0, 1'b1, MC_REQ_E, 1'b0},
          '{R_SEND_GNT_E, 2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b1},
          '{R_RECV_GNT_E, 2'd0, 2'd0, 1'b1, MC_EMPTY, 1'b1}};
    foreach (s[k]) begin
      drive(s[k].rule, s[k].client, s[k].data, 1'b0, s[k].guard, s[k].cmd, s[k].ex);
      #1; tests++;
      if (io_guard !== s[k].guard) begin
        failures++;
        $display("FAIL sat_guard step %0d: io_guard=%0b required %0b", k, io_guard, s[k].guard);
      end
    end
    for (int k = 0; k < 65536; k++)
      drive(R_STORE, 2'd0, k[1:0], 1'b0, 1'b1, MC_EMPTY, 1'b1);
    @(posedge clock); #1;
    tests++;
    if (io_fire_count !== 16'hFFFF || io_fired !== 1'b1) begin
      failures++;
      $display("FAIL sat_count: count=%h fired=%0b, required ffff 1", io_fire_count, io_fired);
    end
    drive(R_IDLE, 2'd0, 2'd0, 1'b0, 1'b0, MC_EMPTY, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exclusive();
    test_store();
    test_shared_inv();
    test_guard_false();
    test_illegal();
    test_reset_override();
    test_saturation();
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clock);
    tests++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d scoreboard entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
